addition_multiply: RTL and testbench



---
 rtl/addition_multiply.sv | 157 +++++++++++++++
 tb/tb_addition_multiply.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/addition_multiply.sv
// Signed 16-bit arithmetic back end: single-cycle add/sub engine plus a 16-iteration shift-add multiplier.
// Optional macro ARITH_SATURATE_EN clamps overflowing results to 0x7FFF / 0x8000 instead of wrapping.
module addition_multiply (
  input  logic        clk,
  input  logic        nRST,
  input  logic [15:0] add_in1,
  input  logic [15:0] add_in2,
  input  logic        sub,
  input  logic        add_start,
  output logic [15:0] add_out,
  output logic        add_ovf,
  output logic        add_finish,
  input  logic [15:0] mult_in1,
  input  logic [15:0] mult_in2,
  input  logic        mult_start,
  output logic [15:0] mult_out,
  output logic        mult_ovf,
  output logic        mult_busy,
  output logic        mult_finish
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // 17 bits so that the magnitude of -32768 is representable
  function automatic logic [16:0] mag17(input logic [15:0] v);
    if (v[15]) begin
      mag17 = {1'b0, ~v} + 17'd1;
    end else begin
      mag17 = {1'b0, v};
    end
  endfunction

  logic [15:0] add_b_s;
  logic [15:0] add_sum_s;
  logic [15:0] add_res_s;
  logic        add_ovf_s;

  mult_state_t state_r;
  logic [3:0]  cnt_r;
  logic [31:0] mcand_r;
  logic [16:0] mplier_r;
  logic [31:0] acc_r;
  logic        sign_r;
  logic [31:0] prod_s;
  logic [15:0] mult_res_s;
  logic        mult_ovf_s;

  // Adder datapath: subtraction as A + ~B + 1, overflow from operand/result signs
  always_comb begin
    add_b_s   = sub ? ~add_in2 : add_in2;
    add_sum_s = add_in1 + add_b_s + {15'd0, sub};
    add_ovf_s = (add_in1[15] == add_b_s[15]) && (add_sum_s[15] != add_in1[15]);
`ifdef ARITH_SATURATE_EN
    if (add_ovf_s) begin
      add_res_s = add_in1[15] ? 16'h8000 : 16'h7FFF;
    end else begin
      add_res_s = add_sum_s;
    end
`else
    add_res_s = add_sum_s;
`endif
  end

  // Adder result register: each accepted request refreshes result, flag and finish
  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      add_out    <= 16'd0;
      add_ovf    <= 1'b0;
      add_finish <= 1'b0;
    end else if (add_start) begin
      add_out    <= add_res_s;
      add_ovf    <= add_ovf_s;
      add_finish <= 1'b1;
    end else begin
      add_finish <= 1'b0;
    end
  end

  // Sign application and range check of the finished accumulator
  always_comb begin
    prod_s     = sign_r ? (~acc_r + 32'd1) : acc_r;
    mult_ovf_s = (prod_s[31:15] != {17{prod_s[31]}});
`ifdef ARITH_SATURATE_EN
    if (mult_ovf_s) begin
      mult_res_s = prod_s[31] ? 16'h8000 : 16'h7FFF;
    end else begin
      mult_res_s = prod_s[15:0];
    end
`else
    mult_res_s = prod_s[15:0];
`endif
  end

  // Multiplier FSM: IDLE accepts, RUN iterates 16 times, DONE publishes the product
  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      mcand_r     <= 32'd0;
      mplier_r    <= 17'd0;
      acc_r       <= 32'd0;
      sign_r      <= 1'b0;
      mult_out    <= 16'd0;
      mult_ovf    <= 1'b0;
      mult_busy   <= 1'b0;
      mult_finish <= 1'b0;
    end else begin
      mult_finish <= 1'b0;
      case (state_r)
        IDLE: begin
          if (mult_start) begin
            mcand_r   <= {15'd0, mag17(mult_in1)};
            mplier_r  <= mag17(mult_in2);
            sign_r    <= mult_in1[15] ^ mult_in2[15];
            acc_r     <= 32'd0;
            cnt_r     <= 4'd0;
            mult_busy <= 1'b1;
            state_r   <= RUN;
          end else begin
            mult_busy <= 1'b0;
          end
        end
        RUN: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end else begin
            acc_r <= acc_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + 4'd1;
          if (cnt_r == 4'd15) begin
            state_r <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          mult_out    <= mult_res_s;
          mult_ovf    <= mult_ovf_s;
          mult_finish <= 1'b1;
          mult_busy   <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          mult_busy <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addition_multiply.sv
// Self-checking bench for addition_multiply: directed and random operands against an integer-arithmetic model.
module tb_addition_multiply;

  logic        clk = 1'b0;
  logic        nRST;
  logic [15:0] add_in1, add_in2;
  logic        sub, add_start;
  logic [15:0] add_out;
  logic        add_ovf, add_finish;
  logic [15:0] mult_in1, mult_in2;
  logic        mult_start;
  logic [15:0] mult_out;
  logic        mult_ovf, mult_busy, mult_finish;

  int tests = 0;
  int fails = 0;

  addition_multiply dut (
    .clk(clk), .nRST(nRST),
    .add_in1(add_in1), .add_in2(add_in2), .sub(sub), .add_start(add_start),
    .add_out(add_out), .add_ovf(add_ovf), .add_finish(add_finish),
    .mult_in1(mult_in1), .mult_in2(mult_in2), .mult_start(mult_start),
    .mult_out(mult_out), .mult_ovf(mult_ovf), .mult_busy(mult_busy), .mult_finish(mult_finish)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
    $fatal(1, "watchdog");
  end

  // reference: exact integer result reduced to 16 bits, {ovf, out}
  function automatic logic [16:0] fit16(input int r);
    logic       ovf;
    logic [15:0] o;
    ovf = (r > 32767) || (r < -32768);
    o = r[15:0];
`ifdef ARITH_SATURATE_EN
    if (r > 32767) o = 16'h7FFF;
    else if (r < -32768) o = 16'h8000;
`endif
    return {ovf, o};
  endfunction

  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic s);
    int ia, ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    return fit16(s ? (ia - ib) : (ia + ib));
  endfunction

  function automatic logic [16:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int ia, ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    return fit16(ia * ib);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [16:0] e;
    e = ref_add(a, b, s);
    add_in1 = a; add_in2 = b; sub = s; add_start = 1'b1;
    @(negedge clk);
    add_start = 1'b0; add_in1 = 16'($urandom); add_in2 = 16'($urandom); sub = 1'($urandom);
    chk("add_finish", 32'(add_finish), 32'd1);
    chk("add_out", 32'(add_out), 32'(e[15:0]));
    chk("add_ovf", 32'(add_ovf), 32'(e[16]));
    @(negedge clk);
    chk("add_finish_drop", 32'(add_finish), 32'd0);
    chk("add_out_held", 32'(add_out), 32'(e[15:0]));
  endtask

  // entered at a negedge with the multiplier idle; returns at the negedge where finish is seen
  task automatic do_mult(input logic [15:0] a, input logic [15:0] b, input logic poke);
    logic [16:0] e;
    int cyc, nbusy;
    e = ref_mul(a, b);
    mult_in1 = a; mult_in2 = b; mult_start = 1'b1;
    @(negedge clk);
    mult_start = 1'b0; mult_in1 = 16'($urandom); mult_in2 = 16'($urandom);
    chk("mult_finish_low_after_accept", 32'(mult_finish), 32'd0);
    cyc = 0; nbusy = 0;
    while (mult_finish !== 1'b1 && cyc < 40) begin
      if (mult_busy === 1'b1) nbusy++;
      mult_start = (poke && (cyc == 5 || cyc == 16)) ? 1'b1 : 1'b0;
      @(negedge clk);
      cyc++;
    end
    mult_start = 1'b0;
    chk("mult_latency", 32'(cyc), 32'd17);
    chk("mult_busy_cycles", 32'(nbusy), 32'd17);
    chk("mult_busy_at_finish", 32'(mult_busy), 32'd0);
    chk("mult_out", 32'(mult_out), 32'(e[15:0]));
    chk("mult_ovf", 32'(mult_ovf), 32'(e[16]));
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [16:0] e;
    int npulse;

    nRST = 1'b1;
    add_in1 = 16'd0; add_in2 = 16'd0; sub = 1'b0; add_start = 1'b0;
    mult_in1 = 16'd0; mult_in2 = 16'd0; mult_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_add_out", 32'(add_out), 32'd0);
    chk("rst_add_flags", 32'({add_ovf, add_finish}), 32'd0);
    chk("rst_mult_out", 32'(mult_out), 32'd0);
    chk("rst_mult_flags", 32'({mult_ovf, mult_busy, mult_finish}), 32'd0);
    nRST = 1'b0;
    @(negedge clk);

    // directed adder cases, including both overflow directions
    do_add(16'd12, 16'd30, 1'b0);
    do_add(16'd5, 16'd9, 1'b1);
    do_add(16'h7FFF, 16'd1, 1'b0);
    do_add(16'h8000, 16'd1, 1'b1);
    do_add(16'h0000, 16'h8000, 1'b1);
    do_add(16'h8000, 16'h8000, 1'b0);

    // start held high: new result and finish every cycle
    for (int i = 0; i < 3; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      e = ref_add(ra, rb, 1'b0);
      add_in1 = ra; add_in2 = rb; sub = 1'b0; add_start = 1'b1;
      @(negedge clk);
      chk("add_held_finish", 32'(add_finish), 32'd1);
      chk("add_held_out", 32'(add_out), 32'(e[15:0]));
    end
    add_start = 1'b0;
    @(negedge clk);
    chk("add_held_drop", 32'(add_finish), 32'd0);

    for (int i = 0; i < 10; i++) do_add(16'($urandom), 16'($urandom), 1'($urandom));

    // directed multiplies, run back to back
    do_mult(16'hFFF9, 16'd6, 1'b0);
    do_mult(16'd300, 16'd300, 1'b0);
    do_mult(16'h8000, 16'd1, 1'b0);
    do_mult(16'h8000, 16'h8000, 1'b0);
    do_mult(16'd0, 16'hFFFF, 1'b0);
    @(negedge clk);
    chk("mult_finish_one_cycle", 32'(mult_finish), 32'd0);
    chk("mult_out_held", 32'(mult_out), 32'(ref_mul(16'd0, 16'hFFFF)));

    // extra starts in RUN and DONE are dropped
    do_mult(16'd123, 16'hFF85, 1'b1);
    npulse = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (mult_finish === 1'b1) npulse++;
    end
    chk("mult_no_queued_finish", 32'(npulse), 32'd0);
    chk("mult_busy_after_poke", 32'(mult_busy), 32'd0);

    // random multiplies, mixing small and full-range operands
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) ra = 16'($urandom_range(0, 400)) - 16'd200;
      else ra = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rb = 16'($urandom_range(0, 400)) - 16'd200;
      else rb = 16'($urandom);
      do_mult(ra, rb, 1'b0);
    end

    // reset in the middle of a multiply: aborted, no finish
    do_mult(16'd77, 16'd5, 1'b0);
    @(negedge clk);
    mult_in1 = 16'd1000; mult_in2 = 16'd1000; mult_start = 1'b1;
    @(negedge clk);
    mult_start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mult_busy_before_reset", 32'(mult_busy), 32'd1);
    nRST = 1'b1;
    #1;
    chk("midrst_mult_out", 32'(mult_out), 32'd0);
    chk("midrst_mult_flags", 32'({mult_ovf, mult_busy, mult_finish}), 32'd0);
    chk("midrst_add_out", 32'(add_out), 32'd0);
    @(negedge clk);
    nRST = 1'b0;
    npulse = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (mult_finish === 1'b1) npulse++;
    end
    chk("midrst_no_finish", 32'(npulse), 32'd0);
    chk("midrst_out_stays_zero", 32'(mult_out), 32'd0);

    do_mult(16'hFFF9, 16'd6, 1'b0);
    do_add(16'd1, 16'hFFFF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
